// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
// Shared definitions for the perceptron datapath blocks (forward evaluation
// and weight update).
//   WORD_W     : width of every weight, bias, accumulator and output word
//   MAX_WORDS  : widest packed word vector that sel_word() can slice
//   state_e    : control states of the serial evaluation stage
//   sel_word() : returns 32-bit word i of a packed word vector
// -----------------------------------------------------------------------------
package perceptron_pkg;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Callers zero-extend their N-word vector to MAX_WORDS words, so a single
    // function serves every block regardless of its own N.
    function automatic logic [WORD_W-1:0] sel_word(
        input logic [WORD_W*MAX_WORDS-1:0] vec,
        input int unsigned                 i
    );
        return vec[i*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/perceptron_eval.sv
// -----------------------------------------------------------------------------
// perceptron_eval
// Serial forward evaluation of a single-layer perceptron:
//   sum = bias + sum over i of (x[i] ? w[i] : 0), one input per clock,
//   y   = (signed sum > THRESH) ? Y_HIGH : Y_LOW.
// Operands are snapshotted when start is accepted, so inputs may change
// freely while an evaluation runs.
// Ports:
//   clk     : system clock, all state on the rising edge
//   rst     : synchronous reset, active low
//   start   : request an evaluation; honoured only while busy is low
//   x       : N binary inputs, x[i] gates weight i
//   weights : N packed two's-complement weights, w[i] = weights[32i+31:32i]
//   bias    : two's-complement bias
//   busy    : evaluation in progress (registered)
//   done    : one-cycle pulse when sum/y have just been updated (registered)
//   sum     : last completed accumulator value
//   y       : last thresholded output
// -----------------------------------------------------------------------------
module perceptron_eval
    import perceptron_pkg::*;
#(
    parameter int                 N      = 8,
    parameter logic [31:0]        Y_HIGH = 32'd1,
    parameter logic [31:0]        Y_LOW  = 32'd0,
    parameter logic signed [31:0] THRESH = 32'sd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          x,
    input  logic [WORD_W*N-1:0]   weights,
    input  logic [WORD_W-1:0]     bias,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_W-1:0]     sum,
    output logic [WORD_W-1:0]     y
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      acc_q, acc_d;
    logic [WORD_W-1:0]      sum_q, sum_d;
    logic [WORD_W-1:0]      y_q, y_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [N-1:0]           x_q, x_d;
    logic [WORD_W*N-1:0]    w_q, w_d;

    logic [WORD_W*MAX_WORDS-1:0] w_ext;
    logic [WORD_W-1:0]           addend;

    // Term contributed by the input currently addressed by idx.
    always_comb begin
        w_ext                 = '0;
        w_ext[WORD_W*N-1:0]   = w_q;
        addend                = x_q[idx_q] ? sel_word(w_ext, 32'(idx_q)) : '0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        x_d     = x_q;
        w_d     = w_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Bias seeds the accumulator, so it needs no copy of its own.
                    x_d     = x;
                    w_d     = weights;
                    acc_d   = bias;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + addend;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                sum_d   = acc_q;
                y_d     = ($signed(acc_q) > THRESH) ? Y_HIGH : Y_LOW;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            y_q     <= Y_LOW;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_q     <= x_d;
            w_q     <= w_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign y    = y_q;

endmodule

// File: tb/tb_perceptron_eval.sv
module tb_perceptron_eval;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic [N-1:0]      x;
    logic [32*N-1:0]   weights;
    logic [31:0]       bias;
    logic              busy, done;
    logic [31:0]       sum, y;

    // Second instance exercising the two-input case (wrap-around test).
    logic              b_start;
    logic [1:0]        b_x;
    logic [63:0]       b_weights;
    logic [31:0]       b_bias;
    logic              b_busy, b_done;
    logic [31:0]       b_sum, b_y;

    perceptron_eval #(.N(N)) u_dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .weights(weights),
        .bias(bias), .busy(busy), .done(done), .sum(sum), .y(y)
    );

    perceptron_eval #(.N(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(b_start), .x(b_x), .weights(b_weights),
        .bias(b_bias), .busy(b_busy), .done(b_done), .sum(b_sum), .y(b_y)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the weighted sum computed directly from the definition.
    function automatic logic [31:0] model_sum(input logic [N-1:0] xv,
                                              input logic [32*N-1:0] wv,
                                              input logic [31:0] b);
        int s;
        s = int'(b);
        for (int i = 0; i < N; i++)
            if (xv[i]) s = s + int'(wv[32*i +: 32]);
        return 32'(s);
    endfunction

    function automatic logic [31:0] model_y(input logic [31:0] s);
        return (int'(s) > 0) ? 32'd1 : 32'd0;
    endfunction

    // Start one evaluation, scramble the inputs right after acceptance and
    // check latency, busy, the one-cycle done pulse and the results.
    task automatic run_eval(input string name, input logic [N-1:0] xv,
                            input logic [32*N-1:0] wv, input logic [31:0] b);
        logic [31:0] exp_s, exp_y;
        int lat;
        bit got, busy_ok;
        exp_s = model_sum(xv, wv, b);
        exp_y = model_y(exp_s);
        x = xv; weights = wv; bias = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = ~xv; bias = ~b; weights = {N{$urandom}};
        lat = 0; got = 1'b0; busy_ok = 1'b1;
        for (int k = 1; k <= 2*N + 4 && !got; k++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1; lat = k;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        check_eq({name, ":latency"}, 32'(lat), 32'(N + 1));
        check_eq({name, ":busy_during"}, {31'd0, busy_ok}, 32'd1);
        check_eq({name, ":sum"}, sum, exp_s);
        check_eq({name, ":y"}, y, exp_y);
        check_eq({name, ":busy_after"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check_eq({name, ":done_pulse"}, {31'd0, done}, 32'd0);
        $display("eval %s x=%b bias=%0d sum=%0d y=%0d lat=%0d", name, xv, $signed(b), $signed(sum), y, lat);
    endtask

    logic [32*N-1:0] w_basic;
    int              cnt, first;
    bit              busy_ok;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        w_basic = {32'd4, 32'd3, 32'd2, 32'd1};
        b_start = 1'b0; b_x = '0; b_weights = '0; b_bias = '0;

        // Reset held with start asserted.
        rst = 1'b0; start = 1'b1; x = 4'b1111; weights = w_basic; bias = 32'd9;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_eq("rst:busy", {31'd0, busy}, 32'd0);
            check_eq("rst:done", {31'd0, done}, 32'd0);
            check_eq("rst:sum", sum, 32'd0);
            check_eq("rst:y", y, 32'd0);
        end
        $display("reset held 3 cycles: busy=%0d done=%0d sum=%0d y=%0d", busy, done, sum, y);
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst:busy", {31'd0, busy}, 32'd0);
        check_eq("post_rst:done", {31'd0, done}, 32'd0);

        // Directed cases with known constants.
        run_eval("basic", 4'b1011, w_basic, -32'sd5);
        check_eq("basic:sum_const", sum, 32'd2);
        run_eval("thresh_eq", 4'b1011, w_basic, -32'sd7);
        check_eq("thresh_eq:y_const", y, 32'd0);
        run_eval("thresh_neg", 4'b1011, w_basic, -32'sd8);
        check_eq("thresh_neg:sum_const", sum, 32'hFFFF_FFFF);

        // Second start during busy must be ignored; only one done pulse.
        x = 4'b1011; weights = w_basic; bias = -32'sd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = 4'b0000;
        cnt = 0; first = 0; busy_ok = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            start = (k == 1);
            if (done) begin
                cnt++;
                if (first == 0) first = k;
            end
            if (k < N + 1 && !busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check_eq("ignore:done_count", 32'(cnt), 32'd1);
        check_eq("ignore:latency", 32'(first), 32'(N + 1));
        check_eq("ignore:busy_during", {31'd0, busy_ok}, 32'd1);
        check_eq("ignore:sum", sum, 32'd2);
        $display("ignore-start: done_count=%0d first=%0d sum=%0d", cnt, first, $signed(sum));

        // Reset in the middle of an evaluation.
        x = 4'b1111; weights = w_basic; bias = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("midrst:busy", {31'd0, busy}, 32'd0);
        check_eq("midrst:sum", sum, 32'd0);
        check_eq("midrst:y", y, 32'd0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) cnt++;
            @(posedge clk); #1;
        end
        check_eq("midrst:no_done", 32'(cnt), 32'd0);
        $display("reset mid-op: busy=%0d sum=%0d y=%0d stray_done=%0d", busy, sum, y, cnt);
        run_eval("after_rst", 4'b1011, w_basic, -32'sd5);

        // Randomised evaluations: alternate small and full-range operands.
        for (int t = 0; t < 24; t++) begin
            logic [32*N-1:0] wv;
            logic [31:0]     bv;
            for (int i = 0; i < N; i++)
                wv[32*i +: 32] = t[0] ? $urandom : 32'($urandom_range(200)) - 32'd100;
            bv = t[0] ? $urandom : 32'($urandom_range(200)) - 32'd100;
            run_eval($sformatf("rand%0d", t), N'($urandom), wv, bv);
        end

        // Two-input instance: modular wrap-around.
        b_x = 2'b11; b_weights = {32'h7FFF_FFFF, 32'h7FFF_FFFF}; b_bias = 32'd2; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0; b_x = 2'b00;
        first = 0;
        for (int k = 1; k <= 8 && first == 0; k++) begin
            @(posedge clk); #1;
            if (b_done) first = k;
        end
        check_eq("wrap:latency", 32'(first), 32'd3);
        check_eq("wrap:sum", b_sum, 32'h0000_0000);
        check_eq("wrap:y", b_y, 32'd0);
        $display("eval wrap N=2 sum=%h y=%0d lat=%0d", b_sum, b_y, first);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/perceptron_eval.md
Name: perceptron_eval

Overview:
Sequential forward-evaluation stage of the single-layer perceptron. It sits directly upstream of the weight-update block. It computes sum = bias + Σ(x[i] ? w[i] : 0) serially, one input per clock, using the current weights/bias vector. It then thresholds the sum to produce the y value the update block consumes. A start/busy/done handshake lets the controller sequence evaluate → train.

Parameters:
N, 8, number of binary inputs (≥1)
Y_HIGH, 32'd1, y value when sum > THRESH
Y_LOW, 32'd0, y value when sum ≤ THRESH
THRESH, 32'sd0, signed activation threshold

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  request evaluation; honoured only when busy=0
x  in  N  binary input vector; x[i] gates weight i
weights  in  32*N  packed weights, w[i] = weights[32i+31:32i], two's complement
bias  in  32  bias, two's complement
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse: sum/y updated
sum  out  32  last completed accumulator value
y  out  32  last thresholded output, feeds the update stage's y

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, idx=0, acc=0, sum=0, y=Y_LOW, busy=0, done=0. Reset overrides every other input, including mid-evaluation: the result is discarded and no done pulse is issued.
- FSM states: IDLE, ACCUM, FINISH.
- IDLE: start=1 at edge E0 → capture x, weights, bias into internal registers. Set acc=bias, idx=0, enter ACCUM, busy=1.
- ACCUM: each edge, acc ← acc + (x_q[idx] ? w_q[idx] : 0) and idx ← idx+1. The edge processing idx=N-1 moves to FINISH. Edges E1..EN cover i=0..N-1.
- FINISH (edge E(N+1)):
  - sum ← acc
  - y ← ($signed(acc) > $signed(THRESH)) ? Y_HIGH : Y_LOW
  - done=1 for exactly one cycle
  - busy=0
  - state=IDLE
- Latency: done is high in the cycle after edge E(N+1), i.e. N+1 edges after start is sampled. Minimum start-to-start period is N+2 cycles.
- start while busy=1 is ignored. It is not queued and does not disturb captured operands.
- Input changes to x/weights/bias after E0 do not affect the running evaluation, because operands are snapshotted.
- Arithmetic: 32-bit two's complement; overflow wraps modulo 2^32 with no saturation. Comparison is signed.
- sum and y hold their values between completions. They change only at FINISH or reset.
- done and busy are registered outputs.
- idx width is $clog2(N) with a minimum of 1 bit. N=1 goes ACCUM → FINISH after a single add.

Decomposition:
- Shared package perceptron_pkg holds:
  - WORD_W=32
  - state enum {IDLE, ACCUM, FINISH}
  - function sel_word(vec, i) returning 32-bit slice i; also used by the weight-update block
- No sub-module required: the accumulator, index counter and FSM are inline.
- The operand snapshot registers may reuse the existing enable-register primitive. Its reset polarity must be adapted to the active-low rst.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 → busy=0, done=0, sum=0, y=0 throughout; release rst → still idle until next start.
- Basic (N=4): w={4,3,2,1} (w[0]=1), bias=-5, x=4'b1011, start pulse → done exactly 5 edges later, sum=1+2+4-5=2, y=1.
- Negative/threshold edge: same weights, bias=-7, x=4'b1011 → sum=0, y=0 (not > THRESH); bias=-8 → sum=-1, y=0.
- Snapshot/ignore: start, then change x to 0 and pulse start again at E2 → result equals the original x computation; only one done pulse; busy stays high until FINISH.
- Wrap: N=2, w[0]=w[1]=32'h7FFF_FFFF, bias=2, x=2'b11 → sum=32'h0000_0000, y=0.
- Reset mid-op: assert rst=0 at E2 of an evaluation → no done, busy=0, sum/y=0; the next start completes normally with correct values.
